serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 Port: cin  input  1  initial carry; captured on the accepted start.
REQ-008 Port: fa_a, fa_b, fa_cin  output  1 each  drive to the external 1-bit full adder cell.
REQ-009 Port: fa_sum, fa_cout  input  1 each  result from the external 1-bit full adder cell.
REQ-010 Port: busy  output  1  high while the addition is in progress.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: sum  output  WIDTH  registered result of the last completed addition.
REQ-013 Port: cout  output  1  registered carry-out of the last completed addition.
REQ-014 Port: ovf  output  1  registered signed overflow of the last completed addition.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL load a and b into shift registers, load cin into the carry register, clear the bit counter, and enter RUN.
REQ-017 In IDLE with start=0, the block SHALL remain in IDLE and hold every output.
REQ-018 In RUN, fa_a SHALL equal the LSB of the A shift register, fa_b the LSB of the B shift register, and fa_cin the carry register, all combinationally.
REQ-019 On each RUN edge, both operand registers SHALL shift right by one, fa_sum SHALL shift into the MSB of the sum shift register, the carry register SHALL load fa_cout, and the counter SHALL increment.
REQ-020 On the RUN edge where the counter equals WIDTH-1, the block SHALL perform the following, then enter DONE:
  - load sum from the completed shift-register value;
  - set cout to fa_cout;
  - set ovf to fa_cin XOR fa_cout.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-022 busy SHALL be 1 exactly in RUN, and done SHALL be 1 exactly in DONE.
REQ-023 Latency: the block SHALL raise done at the WIDTH-th rising edge after the edge that accepted start.
REQ-024 Start asserted in RUN or DONE SHALL be ignored, with no queuing or restart.
REQ-025 When the block is not in RUN, fa_a, fa_b and fa_cin SHALL be 0.
REQ-026 sum, cout and ovf SHALL hold their values from completion until the next completion or reset.
REQ-027 Operand input changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-028 On rst_n=0, the block SHALL immediately force the following, independent of clk:
  - FSM to IDLE;
  - busy, done, sum, cout and ovf to 0;
  - all shift registers, the carry register and the counter to 0.
REQ-029 Reset asserted during RUN SHALL abort the operation, leave no done pulse, and leave the previous results cleared.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-031 The bench SHALL connect the fa_* ports to the team's 1-bit full adder cell and use WIDTH=8.
REQ-032 Scenario: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, ovf=0; done exactly 8 edges after the start edge; busy high for 8 cycles.
REQ-033 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-034 Scenario: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-035 Scenario: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, ovf=0; changing a and b during RUN does not alter the result.
REQ-036 Scenario: start pulsed during RUN and DONE -> ignored, with a single done pulse.
REQ-037 Scenario: rst_n=0 at the 4th RUN cycle -> busy=0, sum=0x00, no done pulse; a fresh start then completes correctly.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving an external 1-bit full adder cell
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic carry, last;
  logic [CW-1:0] cnt;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign last   = busy && cnt == CW'(WIDTH - 1);
  assign fa_a   = busy & a_sr[0];
  assign fa_b   = busy & b_sr[0];
  assign fa_cin = busy & carry;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Overflow is carry into the MSB XOR carry out of it, both visible on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_sum, s_sr[WIDTH-1:1]};
        cout <= fa_cout;
        ovf  <= fa_cin ^ fa_cout;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vector table plus multi-cycle corner sequences for serial_add_ctrl
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout, busy, done, cout, ovf;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  vec_t vecs[9];
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input bit scramble, output int lat, output int busy_cnt);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin a = ~va; b = va ^ vb; cin = ~vc; end
    lat = 0; busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic count_done(input int n, output int pulses, output int busys);
    pulses = 0; busys = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busys++;
    end
  endtask
  initial begin
    int lat, bc, np, nb;
    logic [7:0] held;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {sum, cout, ovf}, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, i == 3, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, 8);
      chk($sformatf("v%0d_busy", i), bc, 8);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].co);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done1", i), {done, busy}, 0);
    end
    held = sum;
    a = 8'h33; b = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", {sum, cout, ovf}, {held, 2'b11});
    chk("idle_fa", {fa_a, fa_b, fa_cin, busy}, 0);
    // start held high through RUN and DONE must not restart or queue
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", lat, 8);
    chk("ign_sum", sum, 8'h30);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_idle", {done, busy}, 0);
    count_done(12, np, nb);
    chk("ign_no_done", np, 0);
    chk("ign_no_busy", nb, 0);
    // reset in the 4th RUN cycle
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {busy, done}, 0);
    chk("abort_res", {sum, cout, ovf}, 0);
    @(negedge clk); rst_n = 1'b1;
    count_done(12, np, nb);
    chk("abort_no_done", np, 0);
    chk("abort_sum", sum, 0);
    do_add(8'h7F, 8'h01, 1'b0, 1'b0, lat, bc);
    chk("post_lat", lat, 8);
    chk("post_res", {sum, cout, ovf}, {8'h80, 1'b0, 1'b1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
